// File: rtl/kdf_pkg.sv
// Shared types and constants for the password verifier and derivation block.
// Holds FSM states, request bundle, hash constant and PRESENT helpers.
package kdf_pkg;

  localparam int KDF_KEY_W = 128;
  localparam logic [63:0] KDF_HASH_C = 64'h1234567812345678;
  localparam int KDF_MAX_FAILS = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    HASH,
    CMP,
    RESP
  } kdf_state_t;

  typedef struct packed {
    logic [31:0]          password;
    logic [63:0]          salt;
    logic [31:0]          count;
    logic [KDF_KEY_W-1:0] ref_key;
  } kdf_req_t;

  function automatic logic [3:0] present_sbox(
    input logic [3:0] x
  );
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // S-box layer followed by the bit permutation
  function automatic logic [63:0] present_round(
    input logic [63:0] s
  );
    logic [63:0] t;
    logic [63:0] p;
    for (int n = 0; n < 16; n++)
      t[4*n +: 4] = present_sbox(s[4*n +: 4]);
    p = '0;
    for (int i = 0; i < 63; i++)
      p[(i*16) % 63] = t[i];
    p[63] = t[63];
    return p;
  endfunction

  function automatic logic [127:0] present_key_upd(
    input logic [127:0] k,
    input logic [4:0]   rc
  );
    logic [127:0] r;
    r = {k[66:0], k[127:67]};
    r[127:124] = present_sbox(r[127:124]);
    r[123:120] = present_sbox(r[123:120]);
    r[66:62] = r[66:62] ^ rc;
    return r;
  endfunction

endpackage

// File: rtl/hirose_present_wrapper.sv
// Hirose double-block hash over PRESENT-128, one round per clock.
// end_signal pulses once, 33 cycles after rst drops; output held until rst.
module hirose_present_wrapper
  import kdf_pkg::*;
#(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_input,
  input  logic [63:0]           c,
  output logic [DATA_WIDTH-1:0] hash_output,
  output logic                  end_signal
);

  logic [5:0]            rnd;
  logic [63:0]           sg;
  logic [63:0]           sh;
  logic [DATA_WIDTH-1:0] key;
  logic [63:0]           g0;
  logic [63:0]           rk;

  assign g0 = data_input[DATA_WIDTH-1 -: 64];
  assign rk = key[DATA_WIDTH-1 -: 64];

  // Two cipher lanes (G and G^c) share one key schedule
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd         <= '0;
      sg          <= '0;
      sh          <= '0;
      key         <= '0;
      hash_output <= '0;
      end_signal  <= 1'b0;
    end else if (rst) begin
      rnd         <= '0;
      sg          <= '0;
      sh          <= '0;
      key         <= '0;
      hash_output <= '0;
      end_signal  <= 1'b0;
    end else if (rnd == 6'd0) begin
      sg  <= g0;
      sh  <= g0 ^ c;
      key <= data_input;
      rnd <= 6'd1;
    end else if (rnd < 6'd32) begin
      sg  <= present_round(sg ^ rk);
      sh  <= present_round(sh ^ rk);
      key <= present_key_upd(key, rnd[4:0]);
      rnd <= rnd + 6'd1;
    end else if (rnd == 6'd32) begin
      hash_output <= {sg ^ rk ^ g0, sh ^ rk ^ g0 ^ c};
      end_signal  <= 1'b1;
      rnd         <= 6'd33;
    end else begin
      end_signal <= 1'b0;
    end
  end

endmodule

// File: rtl/kdf_verifier.sv
// Password verifier: re-derives the key by iterated hashing and compares.
// Optional failed-attempt lockout under KDF_VERIFIER_LOCKOUT_EN.
module kdf_verifier
  import kdf_pkg::*;
#(
  parameter int MAX_FAILS = KDF_MAX_FAILS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [31:0]  password,
  input  logic [63:0]  salt,
  input  logic [31:0]  count,
  input  logic [127:0] ref_key,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_match,
  output logic         rsp_locked,
  output logic         busy
);

  kdf_state_t           state;
  kdf_req_t             req_q;
  logic [31:0]          iter;
  logic [31:0]          iter_nx;
  logic [KDF_KEY_W-1:0] work;
  logic [KDF_KEY_W-1:0] hash_in;
  logic [KDF_KEY_W-1:0] hash_out;
  logic                 hash_end;
  logic                 hash_rst;
  logic                 key_eq;
  logic                 locked;

  assign iter_nx  = iter + 32'd1;
  assign hash_rst = ~rst_n | (state != HASH);
  assign key_eq   = (work == req_q.ref_key);
  assign hash_in  = (iter == 32'd0)
                  ? {req_q.password, req_q.salt, req_q.count}
                  : work;

  hirose_present_wrapper #(
    .DATA_WIDTH (KDF_KEY_W)
  ) u_hash (
    .clk         (clk),
    .rst_n       (rst_n),
    .rst         (hash_rst),
    .data_input  (hash_in),
    .c           (KDF_HASH_C),
    .hash_output (hash_out),
    .end_signal  (hash_end)
  );

`ifdef KDF_VERIFIER_LOCKOUT_EN
  logic [7:0] fail_cnt;

  assign locked = (fail_cnt == 8'(MAX_FAILS));

  // Saturating count of consecutive mismatches; a match clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fail_cnt <= '0;
    else if (state == CMP) begin
      if (key_eq)
        fail_cnt <= '0;
      else if (fail_cnt != 8'hFF)
        fail_cnt <= fail_cnt + 8'd1;
    end
  end
`else
  // MAX_FAILS is at least 1, so the lock never engages here
  assign locked = (MAX_FAILS == 0);
`endif

  // Request FSM with registered handshake and verdict outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_q      <= '0;
      iter       <= '0;
      work       <= '0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_match  <= 1'b0;
      rsp_locked <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_q     <= {password, salt, count, ref_key};
            iter      <= '0;
            work      <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (locked) begin
              state      <= RESP;
              rsp_valid  <= 1'b1;
              rsp_match  <= 1'b0;
              rsp_locked <= 1'b1;
            end else if (count == 32'd0)
              state <= CMP;
            else
              state <= START;
          end
        end
        START: state <= HASH;
        HASH: begin
          if (hash_end) begin
            work  <= hash_out;
            iter  <= iter_nx;
            state <= (iter_nx == req_q.count) ? CMP : START;
          end
        end
        CMP: begin
          rsp_match  <= key_eq;
          rsp_locked <= 1'b0;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state      <= IDLE;
            rsp_valid  <= 1'b0;
            rsp_match  <= 1'b0;
            rsp_locked <= 1'b0;
            busy       <= 1'b0;
            req_ready  <= 1'b1;
            req_q      <= '0;
            work       <= '0;
            iter       <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
